// File: rtl/huff_bit_packer.sv
// -----------------------------------------------------------------------------
// huff_bit_packer
//
// Downstream stage of the Huffman coder. Holds a 64-entry codebook
// ({code, len} per 6-bit symbol) and packs the codes of an incoming symbol
// stream MSB-first into bytes. The final partial byte of a block is
// zero-padded in its low bits and flagged with byte_last.
//
// Optional feature: define HUFF_PACK_BITCNT_EN to add the bit_total output,
// a saturating count of code bits appended in the current block.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start       one-cycle pulse, IDLE -> RUN (ignored outside IDLE)
//   tbl_we      codebook write strobe, honoured only in IDLE
//   tbl_addr    codebook entry (symbol) to write
//   tbl_code    code word, right-justified
//   tbl_len     code length 1..8, 0 marks the entry invalid
//   sym_valid   upstream symbol valid
//   sym_ready   packer can accept a symbol
//   sym_in      symbol
//   sym_last    final symbol of the block
//   byte_valid  byte_out holds a complete byte
//   byte_ready  downstream accepts the byte
//   byte_out    packed byte, first code bit in bit 7
//   byte_last   qualifies the final byte of the block
//   done        one-cycle pulse when the block is fully drained
//   err         sticky: a symbol whose len is 0 was received
//   bit_total   (HUFF_PACK_BITCNT_EN only) code bits appended this block
//   dbg_state_o current FSM state (0 IDLE, 1 RUN, 2 FLUSH, 3 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid keeps its payload stable until the
// transfer. sym_ready and byte_valid are decoded from registered state only,
// so neither depends combinationally on sym_valid or byte_ready.
// -----------------------------------------------------------------------------
module huff_bit_packer #(
    parameter int TBL_DEPTH = 64,
    parameter int ACC_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        tbl_we,
    input  logic [5:0]  tbl_addr,
    input  logic [7:0]  tbl_code,
    input  logic [3:0]  tbl_len,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic [5:0]  sym_in,
    input  logic        sym_last,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_out,
    output logic        byte_last,
    output logic        done,
    output logic        err,
`ifdef HUFF_PACK_BITCNT_EN
    output logic [15:0] bit_total,
`endif
    output logic [1:0]  dbg_state_o
);

    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] CNT_BYTE = CNT_W'(8);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ACC_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Codebook storage. Only the lengths need a reset value: len 0 marks an
    // entry invalid, so the codes behind it are don't-care.
    logic [7:0] code_mem [TBL_DEPTH];
    logic [3:0] len_mem  [TBL_DEPTH];

    logic             tbl_wr;
    logic [3:0]       wr_len;
    logic [7:0]       rd_code;
    logic [3:0]       rd_len;
    logic [7:0]       code_mask;
    logic [7:0]       code_m;
    logic             accept;
    logic             emit;
    logic [ACC_W-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] shamt;
    logic [ACC_W-1:0] app;

    // ------------------------------------------------------------------
    // Output decode from registered state
    // ------------------------------------------------------------------
    assign sym_ready   = (state_q == S_RUN) && (cnt_q <= CNT_BYTE);
    assign byte_valid  = (cnt_q >= CNT_BYTE) ||
                         ((state_q == S_FLUSH) && (cnt_q != '0));
    // In FLUSH the byte holding the last valid bit is the final one.
    assign byte_last   = (state_q == S_FLUSH) && (cnt_q != '0) &&
                         (cnt_q <= CNT_BYTE);
    assign byte_out    = acc_q[ACC_W-1 -: 8];
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign dbg_state_o = state_q;

    assign accept = sym_valid && sym_ready;
    assign emit   = byte_valid && byte_ready;

    // ------------------------------------------------------------------
    // Codebook write and read
    // ------------------------------------------------------------------
    assign tbl_wr = tbl_we && (state_q == S_IDLE);
    // Lengths above 8 are clamped so the accumulator can never overflow.
    assign wr_len = (tbl_len > 4'd8) ? 4'd8 : tbl_len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                len_mem[i] <= 4'd0;
            end
        end else if (tbl_wr) begin
            len_mem[tbl_addr] <= wr_len;
        end
    end

    always_ff @(posedge clk) begin
        if (tbl_wr) begin
            code_mem[tbl_addr] <= tbl_code;
        end
    end

    assign rd_code = code_mem[sym_in];
    assign rd_len  = len_mem[sym_in];

    // ------------------------------------------------------------------
    // Datapath: optional byte drain, then append below the valid bits
    // ------------------------------------------------------------------
    always_comb begin
        code_mask = 8'hFF >> (4'd8 - rd_len);
        code_m    = rd_code & code_mask;

        if (emit) begin
            acc_base = acc_q << 8;
            cnt_base = (cnt_q >= CNT_BYTE) ? (cnt_q - CNT_BYTE) : '0;
        end else begin
            acc_base = acc_q;
            cnt_base = cnt_q;
        end

        // The code MSB lands just below the remaining valid bits. Only used
        // on accept, where cnt_base <= 8 and len <= 8 keep this non-negative.
        shamt = CNT_FULL - cnt_base - CNT_W'(rd_len);
        app   = ACC_W'(code_m) << shamt;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_base;
        cnt_d   = cnt_base;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    acc_d = acc_base | app;
                    cnt_d = cnt_base + CNT_W'(rd_len);
                    if (rd_len == 4'd0) begin
                        err_d = 1'b1;
                    end
                    if (sym_last) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else if (emit && (cnt_q <= CNT_BYTE)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef HUFF_PACK_BITCNT_EN
    logic [15:0] bits_q, bits_d;
    logic [16:0] bits_sum;

    always_comb begin
        bits_sum = {1'b0, bits_q} + 17'(rd_len);
        bits_d   = bits_q;
        if (state_q == S_IDLE && start) begin
            bits_d = 16'd0;
        end else if (state_q == S_RUN && accept) begin
            bits_d = bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
        end
    end

    assign bit_total = bits_q;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef HUFF_PACK_BITCNT_EN
            bits_q  <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef HUFF_PACK_BITCNT_EN
            bits_q  <= bits_d;
`endif
        end
    end

endmodule
